accumulator16bit: RTL and testbench
===================================

Name: accumulator16bit

Overview:
- Sequential accumulate stage built around the 16-bit adder-subtractor datapath.
- Adds or subtracts a stream of 16-bit operands into a running register and keeps sticky carry, borrow and overflow flags.
- Raises a done pulse after a programmed number of operands.
- Sits downstream of the addersubstractor16bit logic and feeds results to later ALU and display stages.

Parameters:
WIDTH, 16, operand/accumulator width in bits
LEN_WIDTH, 4, width of the operand-count field

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a new accumulation; honoured only in IDLE
length  input  LEN_WIDTH  number of operands to accept (0..15), sampled with start
I  input  1  flag mode, sampled with start; 0 = unsigned (outc/borrow), 1 = signed (overflow)
operand  input  WIDTH  data beat
S  input  1  per-beat op select; 0 = add, 1 = subtract; qualified by in_valid
in_valid  input  1  operand/S valid
in_ready  output  1  block accepts a beat this cycle
acc  output  WIDTH  accumulator value
outc  output  1  sticky unsigned carry-out (I=0 only)
borrow  output  1  sticky unsigned borrow (I=0 only)
overflow  output  1  sticky signed overflow (I=1 only)
busy  output  1  high in ACCUM and DONE
done  output  1  one-cycle pulse in DONE

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately including mid-operation.
  - acc=0, outc=0, borrow=0, overflow=0, busy=0, done=0, in_ready=0, state=IDLE, counter=0, mode=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - On start=1 at a clock edge: acc<=0, all flags<=0, mode<=I, counter<=length.
  - Next state is ACCUM if length!=0, else DONE.
  - start=0 holds all outputs, so the previous result stays visible.
- ACCUM:
  - in_ready=1.
  - A beat is accepted on an edge where in_valid&in_ready=1. in_valid=0 stalls indefinitely with no change.
  - On acceptance:
    - acc <= acc + operand when S=0.
    - acc <= acc + ~operand + 1 when S=1.
    - Both are modulo 2^WIDTH.
    - counter decrements.
  - When the accepted beat has counter==1, next state is DONE.
- Per-beat flags, computed on the 17-bit sum and ORed into the sticky outputs:
  - c = carry out of bit WIDTH-1.
  - Add: c_step=c, b_step=0.
  - Subtract: c_step=0, b_step=~c, which equals acc<operand unsigned.
  - v_step (add): acc[MSB]==operand[MSB] and result[MSB]!=acc[MSB].
  - v_step (subtract): acc[MSB]!=operand[MSB] and result[MSB]!=acc[MSB].
  - mode=0: outc|=c_step, borrow|=b_step; overflow stays 0.
  - mode=1: overflow|=v_step; outc and borrow stay 0.
- DONE:
  - done=1, busy=1, in_ready=0 for exactly one cycle, then IDLE.
  - acc and flags hold until the next accepted start.
- Latency: acc and flags update on the accepting edge. done is high in the cycle after the edge that accepted the last beat, or the cycle after start when length=0.
- start while busy=1 is ignored; length and I are not resampled.
- Counter wrap: not possible. length=0 never enters ACCUM.
- Beats offered while in_ready=0 (IDLE/DONE) are not consumed and have no effect.
- One adder-subtractor instance, or equivalent expression, shared by both S modes. No combinational path from in_valid to in_ready.

Test Plan:
- Reset mid-run: length=3, I=0, accept one beat of 500, then pull rst_n low between edges. Required: acc=0, all flags 0, busy=0, in_ready=0 immediately, before the next edge. After release the block is in IDLE.
- Unsigned add: start, I=0, length=3; beats +29, +3, +21 with one idle cycle between the 2nd and 3rd. Required: acc=53, outc=borrow=overflow=0, a single done pulse one cycle after the 3rd acceptance, acc holds 53 afterwards.
- Carry: I=0, length=2; +65534, +65100. Required: acc=65098 (0xFE4A), outc=1, borrow=0.
- Borrow: I=0, length=2; +103, then S=1 with 154. Required: acc=65485 (0xFFCD), borrow=1, outc=0.
- Signed overflow: I=1, length=2; +32400, +32200. Required: acc=0xFC58, overflow=1, outc=borrow=0. Repeat with +16800, S=1 16900. Required: acc=0xFF9C, overflow=0.
- Handshake/edge cases:
  - length=0 start. Required: done pulse on the next cycle, acc=0.
  - start pulsed during ACCUM. Required: ignored, count unchanged.
  - in_valid held high in IDLE. Required: no acceptance, acc unchanged.

Source files
------------

// File: rtl/accumulator16bit.sv
// accumulator16bit: streaming add/subtract accumulator with sticky
// carry, borrow and overflow flags and a done pulse after N operands.
module accumulator16bit #(
   parameter int WIDTH     = 16,
   parameter int LEN_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] length,
   input  logic                 I,
   input  logic [WIDTH-1:0]     operand,
   input  logic                 S,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     acc,
   output logic                 outc,
   output logic                 borrow,
   output logic                 overflow,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic                 outc_q, outc_d;
   logic                 borrow_q, borrow_d;
   logic                 ovf_q, ovf_d;
   logic                 mode_q, mode_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 rdy_q, rdy_d;

   logic [WIDTH-1:0]     opx;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     res;
   logic                 c;
   logic                 c_step;
   logic                 b_step;
   logic                 v_step;
   logic                 accept;

   // Shared adder: subtract is add of the inverted operand plus one.
   always_comb begin
      opx    = S ? ~operand : operand;
      sum    = {1'b0, acc_q} + {1'b0, opx} + {{WIDTH{1'b0}}, S};
      res    = sum[WIDTH-1:0];
      c      = sum[WIDTH];
      c_step = ~S & c;
      b_step = S & ~c;
      v_step = (acc_q[WIDTH-1] == opx[WIDTH-1])
             & (res[WIDTH-1] != acc_q[WIDTH-1]);
      accept = rdy_q & in_valid;
   end

   // Next-state and next-output logic for the control FSM.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      outc_d   = outc_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rdy_d    = rdy_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d    = '0;
               outc_d   = 1'b0;
               borrow_d = 1'b0;
               ovf_d    = 1'b0;
               mode_d   = I;
               cnt_d    = length;
               busy_d   = 1'b1;
               if (length != '0) begin
                  state_d = ACCUM;
                  rdy_d   = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_d = res;
               cnt_d = cnt_q - 1'b1;
               if (mode_q) begin
                  ovf_d = ovf_q | v_step;
               end else begin
                  outc_d   = outc_q | c_step;
                  borrow_d = borrow_q | b_step;
               end
               if (cnt_q == LEN_WIDTH'(1)) begin
                  state_d = DONE;
                  rdy_d   = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            rdy_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            rdy_d   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         outc_q   <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         mode_q   <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         outc_q   <= outc_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rdy_q    <= rdy_d;
      end
   end

   assign in_ready = rdy_q;
   assign acc      = acc_q;
   assign outc     = outc_q;
   assign borrow   = borrow_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_accumulator16bit.sv
// tb_accumulator16bit: directed runs; expected results are queued at
// start and a monitor compares them whenever done pulses.
module tb_accumulator16bit;

   typedef struct packed {
      logic [15:0] acc;
      logic        outc;
      logic        borrow;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  length = '0;
   logic        I = 1'b0;
   logic [15:0] operand = '0;
   logic        S = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] acc;
   logic        outc;
   logic        borrow;
   logic        overflow;
   logic        busy;
   logic        done;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   logic prev_done = 1'b0;

   accumulator16bit #(.WIDTH(16), .LEN_WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .length   (length),
      .I        (I),
      .operand  (operand),
      .S        (S),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .acc      (acc),
      .outc     (outc),
      .borrow   (borrow),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Monitor: one comparison set per done pulse.
   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         checks++;
         if (prev_done) begin
            errors++;
            $display("FAIL done_width: got 2+ cycles want 1");
         end
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got done want none");
         end else begin
            e = sb.pop_front();
            chk("mon_acc", {16'h0, acc}, {16'h0, e.acc});
            chk("mon_outc", {31'h0, outc}, {31'h0, e.outc});
            chk("mon_borrow", {31'h0, borrow}, {31'h0, e.borrow});
            chk("mon_ovf", {31'h0, overflow}, {31'h0, e.ovf});
         end
      end
      prev_done <= rst_n & done;
   end

   task automatic start_run(input logic [3:0] len, input logic mode,
                            input exp_t e, input logic push);
      int n = 0;
      while (busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) begin
         chk("start_timeout", 32'd1, 32'd0);
      end
      if (push) sb.push_back(e);
      start  = 1'b1;
      length = len;
      I      = mode;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic beat(input logic [15:0] op, input logic sub);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("beat_timeout", 32'd1, 32'd0);
      end
      operand  = op;
      S        = sub;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_acc", {16'h0, acc}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_rdy", {31'h0, in_ready}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // reset mid-run
      start_run(4'd3, 1'b0, '0, 1'b0);
      beat(16'd500, 1'b0);
      chk("mid_acc", {16'h0, acc}, 32'd500);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_acc", {16'h0, acc}, 32'h0);
      chk("mrst_flags", {29'h0, outc, borrow, overflow}, 32'h0);
      chk("mrst_busy", {31'h0, busy}, 32'h0);
      chk("mrst_rdy", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", {30'h0, busy, in_ready}, 32'h0);

      // unsigned add with a gap
      e = '{acc: 16'd53, outc: 1'b0, borrow: 1'b0, ovf: 1'b0};
      start_run(4'd3, 1'b0, e, 1'b1);
      beat(16'd29, 1'b0);
      beat(16'd3, 1'b0);
      @(posedge clk); #1;
      chk("gap_acc", {16'h0, acc}, 32'd32);
      beat(16'd21, 1'b0);
      chk("add_done_now", {31'h0, done}, 32'd1);
      @(posedge clk); #1;
      chk("add_done_clr", {31'h0, done}, 32'd0);
      chk("add_hold", {16'h0, acc}, 32'd53);

      // in_valid held high in IDLE
      operand  = 16'd7;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("idle_acc", {16'h0, acc}, 32'd53);
      chk("idle_rdy", {31'h0, in_ready}, 32'd0);

      // carry
      e = '{acc: 16'hFE4A, outc: 1'b1, borrow: 1'b0, ovf: 1'b0};
      start_run(4'd2, 1'b0, e, 1'b1);
      beat(16'd65534, 1'b0);
      beat(16'd65100, 1'b0);

      // borrow
      e = '{acc: 16'hFFCD, outc: 1'b0, borrow: 1'b1, ovf: 1'b0};
      start_run(4'd2, 1'b0, e, 1'b1);
      beat(16'd103, 1'b0);
      beat(16'd154, 1'b1);

      // signed overflow
      e = '{acc: 16'hFC58, outc: 1'b0, borrow: 1'b0, ovf: 1'b1};
      start_run(4'd2, 1'b1, e, 1'b1);
      beat(16'd32400, 1'b0);
      beat(16'd32200, 1'b0);

      // signed subtract, no overflow
      e = '{acc: 16'hFF9C, outc: 1'b0, borrow: 1'b0, ovf: 1'b0};
      start_run(4'd2, 1'b1, e, 1'b1);
      beat(16'd16800, 1'b0);
      beat(16'd16900, 1'b1);

      // length 0
      e = '{acc: 16'h0, outc: 1'b0, borrow: 1'b0, ovf: 1'b0};
      start_run(4'd0, 1'b0, e, 1'b1);
      chk("len0_done", {31'h0, done}, 32'd1);
      chk("len0_acc", {16'h0, acc}, 32'd0);

      // start during ACCUM is ignored
      e = '{acc: 16'd60, outc: 1'b0, borrow: 1'b0, ovf: 1'b0};
      start_run(4'd3, 1'b0, e, 1'b1);
      beat(16'd10, 1'b0);
      start  = 1'b1;
      length = 4'd1;
      I      = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      beat(16'd20, 1'b0);
      chk("ign_busy", {30'h0, busy, in_ready}, 32'd3);
      beat(16'd30, 1'b0);
      chk("ign_done", {31'h0, done}, 32'd1);

      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
